present_enc_core: RTL and testbench

PRESENT_ENC_CORE -- requirements
Module: present_enc_core

---
 rtl/present_enc_core.sv | 160 ++++++++++++++++
 tb/tb_present_enc_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/present_enc_core.sv
// present_enc_core: iterative PRESENT-80 block encryptor, one round per clock.
// Handshaked in (plaintext_i/key_i) and out (ciphertext_o); macro PRESENT_ENC_DBG_EN adds round_o.
// Ports: clk, rst_n (sync, active-low), in_valid_i/in_ready_o, plaintext_i[63:0], key_i[79:0],
//        out_valid_o/out_ready_i, ciphertext_o[63:0], busy_o, [round_o[4:0] with PRESENT_ENC_DBG_EN].
module present_enc_core #(
  parameter int NUM_ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] plaintext_i,
  input  logic [79:0] key_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] ciphertext_o,
  output logic        busy_o
`ifdef PRESENT_ENC_DBG_EN
  ,
  output logic [4:0]  round_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  function automatic logic [3:0] sbox(
    input logic [3:0] x
  );
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] slayer(
    input logic [63:0] x
  );
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++)
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  // bit i -> (16*i) mod 63, bit 63 fixed
  function automatic logic [63:0] player(
    input logic [63:0] x
  );
    logic [63:0] y;
    y = '0;
    y[63] = x[63];
    for (int i = 0; i < 63; i++)
      y[(16*i) % 63] = x[i];
    return y;
  endfunction

  function automatic logic [79:0] key_update(
    input logic [79:0] k,
    input logic [4:0]  rc
  );
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  st_t         st_q, st_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] ct_q, ct_d;
  logic [63:0] rnd;
  logic [79:0] knext;

  assign rnd   = player(slayer(state_q ^ key_q[79:16]));
  assign knext = key_update(key_q, cnt_q);

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = plaintext_i;
          key_d   = key_i;
          cnt_d   = 5'd1;
          st_d    = RUN;
        end
      end
      RUN: begin
        state_d = rnd;
        key_d   = knext;
        if (cnt_q == LAST) begin
          // final whitening with the next round key
          ct_d = rnd ^ knext[79:16];
          st_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready_i)
          st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      ct_q    <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready_o   = (st_q == IDLE);
  assign out_valid_o  = (st_q == DONE);
  assign busy_o       = (st_q != IDLE);
  assign ciphertext_o = ct_q;

`ifdef PRESENT_ENC_DBG_EN
  assign round_o = (st_q == IDLE) ? 5'd0 : cnt_q;
`endif

endmodule

// File: tb/tb_present_enc_core.sv
// tb_present_enc_core: randomized scoreboard bench for present_enc_core.
// Reference model computes PRESENT-80 from round-key list and table lookups.
module tb_present_enc_core;

  localparam int NR = 31;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ciphertext;
  logic        busy;
`ifdef PRESENT_ENC_DBG_EN
  logic [4:0]  round;
`endif

  present_enc_core #(
    .NUM_ROUNDS(NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .plaintext_i (plaintext),
    .key_i       (key),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ciphertext_o(ciphertext),
    .busy_o      (busy)
`ifdef PRESENT_ENC_DBG_EN
    ,
    .round_o     (round)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  int          acc_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] k0);
    logic [63:0] rk [32];
    logic [79:0] k;
    logic [63:0] s, t;
    logic [4:0]  rc;
    k = k0;
    for (int r = 1; r <= NR + 1; r++) begin
      rk[r-1] = k[79:16];
      rc = 5'(r);
      k = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ rc;
    end
    s = pt;
    for (int r = 0; r < NR; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
    end
    return s ^ rk[NR];
  endfunction

  // monitor: pops on each new out_valid, checks hold while stalled
  logic        ov_prev = 1'b0;
  logic [63:0] cur = '0;
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!ov_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", ciphertext, 64'h0);
            checks++;
            errors++;
            $display("FAIL unexpected_output: got valid with empty queue");
          end else begin
            cur = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("ciphertext", ciphertext, cur);
            chk("latency", 64'(cyc - a - 1), 64'(NR));
          end
        end else begin
          chk("ct_hold", ciphertext, cur);
        end
        chk("in_ready_in_done", {63'b0, in_ready}, 64'h0);
      end
      ov_prev = rst_n && out_valid;
    end
  end

  task automatic send(input logic [63:0] pt, input logic [79:0] k,
                      input logic [63:0] exp, input bit hold, output int acc);
    int n = 0;
    plaintext = pt;
    key = k;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
    end else begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
      acc = cyc;
    end
    @(negedge clk);
    in_valid = hold;
    plaintext = {$urandom, $urandom};
    key = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic wait_sig(input bit want_ready, input string nm);
    int n = 0;
    while (((want_ready ? in_ready : out_valid) !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: waited %0d cycles", nm, n);
    end
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_ct"}, ciphertext, 64'h0);
    chk({nm, "_ov"}, {63'b0, out_valid}, 64'h0);
    chk({nm, "_ir"}, {63'b0, in_ready}, 64'h1);
    chk({nm, "_busy"}, {63'b0, busy}, 64'h0);
`ifdef PRESENT_ENC_DBG_EN
    chk({nm, "_round"}, {59'b0, round}, 64'h0);
`endif
  endtask

  initial begin
    int acc;
    int b2b [4];
    logic [63:0] pt;
    logic [95:0] kr;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
    key = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // known-answer vectors
    send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, acc);
    wait_sig(1'b1, "idle");
    send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, acc);
    wait_sig(1'b1, "idle");
    send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, acc);
    wait_sig(1'b1, "idle");
    send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, acc);
    wait_sig(1'b1, "idle");

    // stall 10 cycles with ignored input pulses
    out_ready = 1'b0;
    pt = {$urandom, $urandom};
    kr = {$urandom, $urandom, $urandom};
    send(pt, kr[79:0], present_ref(pt, kr[79:0]), 1'b0, acc);
    wait_sig(1'b0, "out_valid");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      plaintext = {$urandom, $urandom};
      key = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_sig(1'b1, "idle");

    // reset mid-run aborts the block
    pt = {$urandom, $urandom};
    kr = {$urandom, $urandom, $urandom};
    send(pt, kr[79:0], present_ref(pt, kr[79:0]), 1'b0, acc);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;
    pt = {$urandom, $urandom};
    kr = {$urandom, $urandom, $urandom};
    send(pt, kr[79:0], present_ref(pt, kr[79:0]), 1'b0, acc);
    wait_sig(1'b1, "idle");

    // random vectors with random output stalls
    for (int v = 0; v < 8; v++) begin
      pt = {$urandom, $urandom};
      kr = {$urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      send(pt, kr[79:0], present_ref(pt, kr[79:0]), 1'b0, acc);
      wait_sig(1'b0, "out_valid");
      repeat ($urandom_range(0, 4)) @(negedge clk);
      out_ready = 1'b1;
      wait_sig(1'b1, "idle");
    end

    // back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      pt = {$urandom, $urandom};
      kr = {$urandom, $urandom, $urandom};
      send(pt, kr[79:0], present_ref(pt, kr[79:0]), v != 3, acc);
      b2b[v] = acc;
    end
    for (int v = 0; v < 3; v++)
      chk("b2b_period", 64'(b2b[v+1] - b2b[v]), 64'(NR + 2));
    wait_sig(1'b1, "idle");
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
